// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter, registered write port and RAW scoreboard
//
// Two writeback sources share the single integer register-file write port. The
// winner of the round-robin arbiter is registered for one cycle and then drives
// rf_we/rf_waddr/rf_wdata. A per-register pending scoreboard lets issue logic
// stall reads of registers whose producing write has not yet committed.
//
// Ports:
//   clk, rst                      core clock; asynchronous active-high reset
//   flush                         synchronous flush: clears scoreboard, drops output stage
//   src0_valid/ready/rd/data      ALU/CSR writeback request and handshake
//   src1_valid/ready/rd/data      load-unit writeback request and handshake
//   issue_valid, issue_rd         destination of an issuing instruction (sets pending)
//   rs1_addr/rs1_busy             scoreboard query 1 (combinational)
//   rs2_addr/rs2_busy             scoreboard query 2 (combinational)
//   rf_we, rf_waddr, rf_wdata     register-file write port
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            src0_valid,
  output logic            src0_ready,
  input  logic [AW-1:0]   src0_rd,
  input  logic [XLEN-1:0] src0_data,
  input  logic            src1_valid,
  output logic            src1_ready,
  input  logic [AW-1:0]   src1_rd,
  input  logic [XLEN-1:0] src1_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  // rr_q == 0 favours src0 on a tie, rr_q == 1 favours src1
  logic            rr_q, rr_d;
  logic            gnt0, gnt1, hs;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  // bit 0 is kept at zero so x0 never reads as pending
  logic [NREG-1:0] sb_q, sb_d;

  // Arbiter: flush masks both grants so no handshake can complete.
  always_comb begin
    gnt0     = !flush && src0_valid && (!src1_valid || !rr_q);
    gnt1     = !flush && src1_valid && (!src0_valid ||  rr_q);
    hs       = gnt0 || gnt1;
    win_rd   = gnt1 ? src1_rd   : src0_rd;
    win_data = gnt1 ? src1_data : src0_data;
  end

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;

  // After a contended cycle the loser becomes favoured; flush leaves it alone.
  always_comb begin
    rr_d = rr_q;
    if (src0_valid && src1_valid && !flush) begin
      rr_d = gnt0;
    end
  end

  // Output stage: writes to x0 are accepted but never raise rf_we.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (hs) begin
      rf_we_d    = (win_rd != '0);
      rf_waddr_d = win_rd;
      rf_wdata_d = win_data;
    end
  end

  // Scoreboard: clear on commit, then set on issue so a same-index set wins.
  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      sb_d = '0;
    end else begin
      if (rf_we_q) begin
        sb_d[rf_waddr_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
        sb_d[issue_rd] = 1'b1;
      end
    end
    sb_d[0] = 1'b0;
  end

  // A write sitting in the output stage still counts as pending until its commit edge.
  always_comb begin
    rs1_busy = (rs1_addr != '0) && (sb_q[rs1_addr] || (rf_we_q && (rf_waddr_q == rs1_addr)));
    rs2_busy = (rs2_addr != '0) && (sb_q[rs2_addr] || (rf_we_q && (rf_waddr_q == rs2_addr)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sb_q       <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sb_q       <= sb_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        src0_valid, src0_ready;
  logic [4:0]  src0_rd;
  logic [63:0] src0_data;
  logic        src1_valid, src1_ready;
  logic [4:0]  src1_rd;
  logic [63:0] src1_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  regfile_wb_arbiter #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: set of pending registers, the one write waiting to commit,
  // and which source wins the next tie.
  bit          m_pend [32];
  int          m_fav;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit exp_ready0();
    return !flush && src0_valid && (!src1_valid || m_fav == 0);
  endfunction

  function automatic bit exp_ready1();
    return !flush && src1_valid && (!src0_valid || m_fav == 1);
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return (a != 0) && (m_pend[a] || (m_we && m_waddr == a));
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_fav   = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Applies the rules for one clock edge using the inputs that were stable before it.
  task automatic model_update();
    bit g0, g1;
    g0 = exp_ready0();
    g1 = exp_ready1();
    if (src0_valid && src1_valid && !flush) m_fav = g0 ? 1 : 0;
    if (flush) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
    if (g0 || g1) begin
      m_waddr = g0 ? src0_rd : src1_rd;
      m_wdata = g0 ? src0_data : src1_data;
      m_we    = (m_waddr != 0);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic compare_model();
    chk("src0_ready", src0_ready, exp_ready0());
    chk("src1_ready", src1_ready, exp_ready1());
    chk("rs1_busy",   rs1_busy,   exp_busy(rs1_addr));
    chk("rs2_busy",   rs2_busy,   exp_busy(rs2_addr));
    chk("rf_we",      rf_we,      m_we);
    chk("rf_waddr",   rf_waddr,   m_waddr);
    chk("rf_wdata",   rf_wdata,   m_wdata);
  endtask

  // Inputs are driven at negedge; settle samples mid-low-phase, tick crosses one posedge.
  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; src0_valid = 0; src1_valid = 0; issue_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0;
    src0_valid = 0; src0_rd = 0; src0_data = 0;
    src1_valid = 0; src1_rd = 0; src1_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;

    // reset state
    settle();
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_rf_waddr", rf_waddr, 5'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_rs1_busy", rs1_busy, 1'b0);
    tick();

    // single src0 write
    src0_valid = 1; src0_rd = 5; src0_data = 64'hDEAD; rs1_addr = 5;
    settle();
    chk("single_ready0", src0_ready, 1'b1);
    chk("single_ready1", src1_ready, 1'b0);
    tick();
    idle();
    settle();
    chk("single_we", rf_we, 1'b1);
    chk("single_waddr", rf_waddr, 5'd5);
    chk("single_wdata", rf_wdata, 64'hDEAD);
    chk("single_busy_in_stage", rs1_busy, 1'b1);
    tick();
    settle();
    chk("single_we_drop", rf_we, 1'b0);
    tick();

    // contention: grants alternate starting with src0
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        src0_valid = 1; src0_rd = 1; src0_data = 64'h11;
        src1_valid = 1; src1_rd = 2; src1_data = 64'h22;
      end else begin
        idle();
      end
      settle();
      if (i < 4) chk("rr_ready0", src0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (i > 0) chk("rr_waddr", rf_waddr, ((i - 1) % 2 == 0) ? 5'd1 : 5'd2);
      tick();
    end

    // x0 write is accepted but never written
    src1_valid = 1; src1_rd = 0; src1_data = 64'h55; rs1_addr = 0;
    settle();
    chk("x0_ready1", src1_ready, 1'b1);
    chk("x0_busy", rs1_busy, 1'b0);
    tick();
    idle();
    settle();
    chk("x0_no_we", rf_we, 1'b0);
    tick();

    // scoreboard set by issue, cleared by commit
    issue_valid = 1; issue_rd = 7; rs1_addr = 7;
    settle();
    chk("sb_c0_busy", rs1_busy, 1'b0);
    tick();
    idle();
    settle();
    chk("sb_c1_busy", rs1_busy, 1'b1);
    tick();
    settle();
    tick();
    src0_valid = 1; src0_rd = 7; src0_data = 64'h77;
    settle();
    chk("sb_c3_busy", rs1_busy, 1'b1);
    tick();
    idle();
    settle();
    chk("sb_c4_we", rf_we, 1'b1);
    chk("sb_c4_busy", rs1_busy, 1'b1);
    tick();
    settle();
    chk("sb_c5_busy", rs1_busy, 1'b0);
    tick();

    // commit to x9 coinciding with issue to x9: set wins
    src0_valid = 1; src0_rd = 9; src0_data = 64'h99; rs1_addr = 9;
    settle();
    tick();
    idle();
    issue_valid = 1; issue_rd = 9;
    settle();
    chk("collide_we", rf_we, 1'b1);
    tick();
    idle();
    settle();
    chk("collide_busy", rs1_busy, 1'b1);
    tick();

    // flush clears pending x3/x4 and blocks the handshake
    issue_valid = 1; issue_rd = 3;
    settle(); tick();
    issue_rd = 4;
    settle(); tick();
    idle();
    src0_valid = 1; src0_rd = 3; src0_data = 64'h33; flush = 1;
    rs1_addr = 3; rs2_addr = 4;
    settle();
    chk("flush_ready0", src0_ready, 1'b0);
    chk("flush_pre_busy1", rs1_busy, 1'b1);
    tick();
    idle();
    settle();
    chk("flush_busy1", rs1_busy, 1'b0);
    chk("flush_busy2", rs2_busy, 1'b0);
    chk("flush_we", rf_we, 1'b0);
    tick();

    // asynchronous reset while a write sits in the output stage
    src0_valid = 1; src0_rd = 6; src0_data = 64'h66;
    settle();
    tick();
    idle();
    settle();
    chk("areset_pre_we", rf_we, 1'b1);
    #2 rst = 1;
    #1;
    chk("areset_we", rf_we, 1'b0);
    chk("areset_waddr", rf_waddr, 5'd0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      narrow      = $urandom_range(0, 1);
      src0_valid  = $urandom_range(0, 1);
      src1_valid  = $urandom_range(0, 1);
      src0_rd     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      src1_rd     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      src0_data   = {$urandom, $urandom};
      src1_data   = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs1_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 15) == 0);
      settle();
      tick();
    end
    idle();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 31x64-bit integer register file between two writeback sources: ALU/CSR (src0) and load unit (src1). Uses round-robin arbitration with valid/ready handshakes and registers the winning write for one cycle before driving the register-file write port. Maintains a per-register pending scoreboard so issue logic can stall read-after-write hazards on rs1/rs2 until the producing write commits.

Parameters:
XLEN, 64, data width of register write data
NREG, 32, architectural register count; index width is 5 bits

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous pipeline flush; clears scoreboard and discards the output stage
src0_valid  input  1  ALU/CSR writeback request
src0_ready  output  1  src0 accepted this cycle
src0_rd  input  5  src0 destination register
src0_data  input  XLEN  src0 write data
src1_valid  input  1  load writeback request
src1_ready  output  1  src1 accepted this cycle
src1_rd  input  5  src1 destination register
src1_data  input  XLEN  src1 write data
issue_valid  input  1  an instruction with a destination issues this cycle
issue_rd  input  5  destination of the issuing instruction
rs1_addr  input  5  scoreboard query 1
rs2_addr  input  5  scoreboard query 2
rs1_busy  output  1  rs1_addr has a pending write (combinational)
rs2_busy  output  1  rs2_addr has a pending write (combinational)
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  XLEN  register-file write data

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, scoreboard all 0, rr pointer=0 (src0 favoured); ready outputs reflect the arbiter combinationally.
- Arbitration (combinational): one valid -> that source is granted. Both valid -> grant the source pointed to by the rr pointer. A handshake occurs when srcN_valid && srcN_ready. At most one ready is high per cycle. src_ready is low during flush.
- rr pointer: after any cycle in which both sources were valid, the pointer moves to the non-granted source. It is unchanged otherwise. Worst-case wait is therefore one grant.
- Output stage: on posedge following a handshake, rf_we<=(rd!=0), rf_waddr<=rd, rf_wdata<=data. With no handshake, rf_we<=0 and rf_waddr/rf_wdata hold their values. Latency is exactly 1 cycle from handshake to rf_we. The register file samples on negedge within that cycle.
- rd==0: still handshaken (ready asserted normally); rf_we stays 0; scoreboard untouched.
- Scoreboard: 31 bits (x0 hardwired to 0).
  - Set: issue_valid && issue_rd!=0 sets bit issue_rd at posedge.
  - Clear: the bit for rf_waddr clears at the posedge ending the cycle in which rf_we=1 (write committed).
  - Simultaneous set and clear of the same index: set wins.
  - Set or clear of different indices in the same cycle: both apply.
- Busy outputs: rsN_busy = bit[rsN_addr], plus bypass-free hazard coverage. rsN_busy is also 1 if the output stage holds a pending rf_we to rsN_addr, so a query always sees busy until the commit edge. rsN_busy is 0 for address 0.
- Flush: at posedge, scoreboard<=0, rf_we<=0, and any same-cycle handshake is suppressed (ready low). Flush has priority over issue set. The rr pointer is preserved.
- Async reset mid-operation: all state returns to reset values immediately. A pending output-stage write is dropped.

Test Plan:
- Single src0: src0_valid=1, rd=5, data=0xDEAD -> src0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEAD; then rf_we=0.
- Contention: both valid every cycle (src0 rd=1, src1 rd=2) for 4 cycles -> grants src0, src1, src0, src1; rf_waddr sequence 1, 2, 1, 2.
- x0 write: src1_valid=1, rd=0, data=0x55 -> src1_ready=1; rf_we stays 0; rs1_addr=0 -> rs1_busy=0.
- Scoreboard: issue rd=7 at cycle 0 -> rs1_busy=1 for rs1_addr=7 from cycle 1; src0 write rd=7 at cycle 3 -> busy through cycle 4 (rf_we=1), 0 at cycle 5.
- Set/clear collision: commit to x9 coincides with issue_valid rd=9 -> bit 9 remains 1 after the edge.
- Flush and reset: scoreboard holds x3 and x4 pending and src0 valid; assert flush -> src0_ready=0, next cycle rs busy=0 for x3 and x4, rf_we=0. Pulse rst asynchronously mid-write -> rf_we drops to 0 immediately.
